pc_ras: RTL
===========

PC_RAS -- requirements
Module: pc_ras

Interface
REQ-001 The block SHALL have parameter PC_INIT, default 32'h0000_0000, reset PC value, word-aligned.
REQ-002 The block SHALL have parameter WIDTH, default 32, address width, >= 28.
REQ-003 The block SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries, power of two, 2..16.
REQ-004 The block SHALL have port CLK  in  1  clock, rising edge.
REQ-005 The block SHALL have port nRST  in  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port pcEN  in  1  advance PC this cycle.
REQ-007 The block SHALL have port pc_src  in  3  next-PC mode: 0 seq, 1 branch, 2 j, 3 jr, 4 jal, 5 jr-ra.
REQ-008 The block SHALL have port branch_taken  in  1  branch condition, used when pc_src=1.
REQ-009 The block SHALL have port branch_target  in  WIDTH  branch destination.
REQ-010 The block SHALL have port imm26  in  26  jump index.
REQ-011 The block SHALL have port regval  in  WIDTH  register jump target.
REQ-012 The block SHALL have port redirect  in  1  pipeline flush request.
REQ-013 The block SHALL have port redirect_addr  in  WIDTH  flush target.
REQ-014 The block SHALL have port imemaddr  out  WIDTH  current PC.
REQ-015 The block SHALL have port pc_plus4  out  WIDTH  imemaddr+4, combinational.
REQ-016 The block SHALL have port ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries.
REQ-017 The block SHALL have port ras_empty / ras_full  out  1 each  ras_count==0 / ras_count==RAS_DEPTH.
REQ-018 The block SHALL have port ras_mispredict  out  1  registered pulse, jr-ra target disagreed with regval.

Function
REQ-019 The block SHALL add modulo 2^WIDTH throughout; pc_plus4 wraps from all-ones-minus-3 to 0.
REQ-020 The block SHALL compute the next PC as: mode 0 pc_plus4; mode 1 branch_target if branch_taken else pc_plus4; modes 2/4 {pc_plus4[WIDTH-1:28], imm26, 2'b00}; mode 3 regval; mode 5 RAS top if !ras_empty else regval; modes 6/7 pc_plus4.
REQ-021 The block SHALL load imemaddr with the next PC on the rising edge when pcEN=1, and SHALL hold imemaddr when pcEN=0, giving a latency of one cycle.
REQ-022 On redirect=1 the block SHALL load redirect_addr on the next edge regardless of pcEN and pc_src, SHALL leave the RAS untouched, and SHALL not assert ras_mispredict.
REQ-023 In mode 4 with pcEN=1 and redirect=0, the block SHALL push pc_plus4 onto the RAS.
REQ-024 When mode 4 pushes onto a full RAS, the block SHALL overwrite the oldest entry as a circular buffer, and ras_count SHALL stay at RAS_DEPTH.
REQ-025 In mode 5 with pcEN=1 and redirect=0, the block SHALL pop the RAS if it is non-empty; an empty RAS SHALL pop nothing and ras_count SHALL stay 0.
REQ-026 A mode-5 pop SHALL assert ras_mispredict for exactly one cycle after the edge when the RAS top != regval; the PC SHALL still take the RAS top, and recovery is by redirect.
REQ-027 The block SHALL not alter RAS contents or ras_count when pcEN=0, including for modes 4 and 5.
REQ-028 ras_mispredict SHALL be 0 in every cycle not covered by REQ-026.

Reset
REQ-029 While nRST=0 the block SHALL asynchronously force imemaddr=PC_INIT, ras_count=0 and ras_mispredict=0; RAS entry contents are don't-care.
REQ-030 A reset asserted mid-operation SHALL discard any pending push or pop, and the first edge after release SHALL behave as a normal cycle from PC_INIT.

Verification
REQ-031 The bench SHALL cover reset then pc_src=0, pcEN=1 for 3 cycles -> imemaddr 0x0, 0x4, 0x8, 0xC; pcEN=0 next cycle -> 0xC held.
REQ-032 The bench SHALL cover imemaddr=0x100, pc_src=4, imm26=0x40 -> next 0x100, ras_count=1; later pc_src=5, regval=0x104 -> 0x104, ras_count=0, no mispredict.
REQ-033 The bench SHALL cover RAS_DEPTH=4 with 5 jal pushes of return addresses A1..A5 -> ras_count=4, ras_full=1; 4 pops return A5, A4, A3, A2; a 5th pop uses regval, ras_count=0.
REQ-034 The bench SHALL cover a pop with RAS top 0x204 and regval=0x300 -> PC=0x204, ras_mispredict=1 for one cycle; redirect_addr=0x300 next -> PC=0x300.
REQ-035 The bench SHALL cover redirect=1, redirect_addr=0x800, pcEN=0, pc_src=4 -> PC=0x800, ras_count unchanged.
REQ-036 The bench SHALL cover imemaddr=0xFFFF_FFFC, pc_src=0 -> 0x0; nRST pulsed low between clock edges -> imemaddr=PC_INIT immediately.

Source files
------------

// File: rtl/pc_ras.sv
`default_nettype none
// ============================================================================
// Module      : pc_ras
// Description : Program counter with next-PC selection (sequential, branch,
//               jump, jump-register, jal, return) and a circular return
//               address stack that predicts return targets and flags
//               mispredictions.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_ras #(
    parameter int unsigned          WIDTH     = 32,
    parameter logic [WIDTH-1:0]     PC_INIT   = '0,
    parameter int unsigned          RAS_DEPTH = 4
) (
    input  logic                          CLK,
    input  logic                          nRST,
    input  logic                          pcEN,
    input  logic [2:0]                    pc_src,
    input  logic                          branch_taken,
    input  logic [WIDTH-1:0]              branch_target,
    input  logic [25:0]                   imm26,
    input  logic [WIDTH-1:0]              regval,
    input  logic                          redirect,
    input  logic [WIDTH-1:0]              redirect_addr,
    output logic [WIDTH-1:0]              imemaddr,
    output logic [WIDTH-1:0]              pc_plus4,
    output logic [$clog2(RAS_DEPTH):0]    ras_count,
    output logic                          ras_empty,
    output logic                          ras_full,
    output logic                          ras_mispredict
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RAS_DEPTH);

    localparam logic [2:0] SRC_SEQ    = 3'd0;
    localparam logic [2:0] SRC_BRANCH = 3'd1;
    localparam logic [2:0] SRC_J      = 3'd2;
    localparam logic [2:0] SRC_JR     = 3'd3;
    localparam logic [2:0] SRC_JAL    = 3'd4;
    localparam logic [2:0] SRC_JR_RA  = 3'd5;

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [PTR_W-1:0] sp_q;
    logic [PTR_W-1:0] sp_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             mis_q;
    logic             mis_d;

    logic [WIDTH-1:0] w_pc_plus4;
    logic [WIDTH-1:0] w_jump_target;
    logic [WIDTH-1:0] w_next_pc;
    logic [PTR_W-1:0] w_top_idx;
    logic [WIDTH-1:0] w_ras_top;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    assign w_pc_plus4 = pc_q + WIDTH'(4);
    assign w_empty    = (cnt_q == '0);
    assign w_full     = (cnt_q == DEPTH_CNT);

    // sp_q is the next write slot, so the newest entry sits one below it.
    assign w_top_idx  = sp_q - PTR_W'(1);
    assign w_ras_top  = ras_q[w_top_idx];

    // Jump target keeps the upper region bits of pc_plus4 when any exist.
    generate
        if (WIDTH > 28) begin : g_jump_region
            assign w_jump_target = {w_pc_plus4[WIDTH-1:28], imm26, 2'b00};
        end else begin : g_jump_flat
            assign w_jump_target = {imm26, 2'b00};
        end
    endgenerate

    // A redirect suppresses all stack activity so a flushed jal/return has no side effects.
    assign w_push = pcEN & ~redirect & (pc_src == SRC_JAL);
    assign w_pop  = pcEN & ~redirect & (pc_src == SRC_JR_RA) & ~w_empty;

    // Select the architectural next PC from the requested mode.
    always_comb begin
        w_next_pc = w_pc_plus4;
        case (pc_src)
            SRC_SEQ:    w_next_pc = w_pc_plus4;
            SRC_BRANCH: w_next_pc = branch_taken ? branch_target : w_pc_plus4;
            SRC_J:      w_next_pc = w_jump_target;
            SRC_JR:     w_next_pc = regval;
            SRC_JAL:    w_next_pc = w_jump_target;
            SRC_JR_RA:  w_next_pc = w_empty ? regval : w_ras_top;
            default:    w_next_pc = w_pc_plus4;
        endcase
    end

    // Next-state for PC, stack pointer, occupancy and the mispredict pulse.
    always_comb begin
        pc_d  = pc_q;
        sp_d  = sp_q;
        cnt_d = cnt_q;
        mis_d = 1'b0;
        if (redirect) begin
            pc_d = redirect_addr;
        end else if (pcEN) begin
            pc_d = w_next_pc;
        end
        if (w_push) begin
            // A full stack wraps and overwrites its oldest entry.
            sp_d = sp_q + PTR_W'(1);
            if (!w_full) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (w_pop) begin
            sp_d  = sp_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
            mis_d = (w_ras_top != regval);
        end
    end

    // Control state with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc_q  <= PC_INIT;
            sp_q  <= '0;
            cnt_q <= '0;
            mis_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
            mis_q <= mis_d;
        end
    end

    // Stack storage; contents need no reset because occupancy gates their use.
    always_ff @(posedge CLK) begin
        if (nRST && w_push) begin
            ras_q[sp_q] <= w_pc_plus4;
        end
    end

    assign imemaddr       = pc_q;
    assign pc_plus4       = w_pc_plus4;
    assign ras_count      = cnt_q;
    assign ras_empty      = w_empty;
    assign ras_full       = w_full;
    assign ras_mispredict = mis_q;

endmodule
`default_nettype wire
